// File: rtl/step_command_engine.sv
// step_command_engine: decodes 32-bit host command words and runs NUM_MOTORS
// independent step generators (divisor, direction, microsteps, step budget).
module step_command_engine #(
  parameter int NUM_MOTORS  = 2,
  parameter int DIV_WIDTH   = 24,
  parameter int COUNT_WIDTH = 24,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic                    word_received,
  input  logic [31:0]             word_data_received,
  output logic [31:0]             word_send_data,
  output logic [NUM_MOTORS-1:0]   step,
  output logic [NUM_MOTORS-1:0]   dir,
  output logic [3*NUM_MOTORS-1:0] microsteps,
  output logic [NUM_MOTORS-1:0]   busy,
  output logic [NUM_MOTORS-1:0]   move_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state_q [NUM_MOTORS];
  state_t                 state_d [NUM_MOTORS];
  logic [DIV_WIDTH-1:0]   div_q   [NUM_MOTORS];
  logic [DIV_WIDTH-1:0]   div_d   [NUM_MOTORS];
  logic [DIV_WIDTH-1:0]   cnt_q   [NUM_MOTORS];
  logic [DIV_WIDTH-1:0]   cnt_d   [NUM_MOTORS];
  logic [COUNT_WIDTH-1:0] rem_q   [NUM_MOTORS];
  logic [COUNT_WIDTH-1:0] rem_d   [NUM_MOTORS];
  logic [2:0]             ustep_q [NUM_MOTORS];
  logic [2:0]             ustep_d [NUM_MOTORS];
  logic [NUM_MOTORS-1:0]  dir_q, dir_d, step_q, step_d, done_q, done_d;
  logic                   error_q, error_d;
  logic [31:0]            resp_q, resp_d;
  logic [3:0]             op, ch;
  logic [23:0]            pl;
  assign op = word_data_received[31:28];
  assign ch = word_data_received[27:24];
  assign pl = word_data_received[23:0];
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ustep_d = ustep_q;
    dir_d   = dir_q;
    step_d  = '0;
    done_d  = '0;
    error_d = error_q;
    resp_d  = resp_q;
    for (int c = 0; c < NUM_MOTORS; c++) begin
      if (state_q[c] == RUN && cnt_q[c] >= div_q[c]) begin
        step_d[c] = 1'b1;
        cnt_d[c]  = '0;
        rem_d[c]  = rem_q[c] - 1'b1;
        if (rem_q[c] == COUNT_WIDTH'(1)) begin
          state_d[c] = IDLE;
          done_d[c]  = 1'b1;
        end
      end else begin
        cnt_d[c] = (state_q[c] == RUN) ? cnt_q[c] + 1'b1 : '0;
      end
    end
    if (word_received) begin
      resp_d = word_data_received;
      // Status reports the error seen before this word; any new error below overrides the clear.
      if (op == 4'h7) begin
        resp_d  = {4'h7, 4'h0, error_q, 15'b0, 8'(busy)};
        error_d = 1'b0;
      end
      if (op >= 4'h1 && op <= 4'h6 && ch >= 4'(NUM_MOTORS)) error_d = 1'b1;
      for (int c = 0; c < NUM_MOTORS; c++) begin
        if (ch == 4'(c)) begin
          if (op == 4'h1 || op == 4'h2) begin
            if (state_q[c] == RUN) error_d = 1'b1;
            else if (pl[COUNT_WIDTH-1:0] != '0) begin
              state_d[c] = RUN;
              rem_d[c]   = pl[COUNT_WIDTH-1:0];
              dir_d[c]   = (op == 4'h2);
              cnt_d[c]   = '0;
            end
          end
          if (op == 4'h3) div_d[c] = (pl[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : pl[DIV_WIDTH-1:0];
          if (op == 4'h4) ustep_d[c] = pl[2:0];
          if (op == 4'h5) begin
            state_d[c] = IDLE;
            rem_d[c]   = '0;
            cnt_d[c]   = '0;
            step_d[c]  = 1'b0;
            done_d[c]  = 1'b0;
          end
          if (op == 4'h6) resp_d = {4'h6, ch, 24'(rem_q[c])};
        end
      end
    end
  end
  always_comb begin
    busy       = '0;
    microsteps = '0;
    for (int c = 0; c < NUM_MOTORS; c++) begin
      busy[c]            = (state_q[c] == RUN);
      microsteps[3*c +: 3] = ustep_q[c];
    end
  end
  assign step           = step_q;
  assign dir            = dir_q;
  assign move_done      = done_q;
  assign word_send_data = resp_q;
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_MOTORS; c++) begin
        state_q[c] <= IDLE;
        div_q[c]   <= DIV_WIDTH'(DEFAULT_DIV);
        cnt_q[c]   <= '0;
        rem_q[c]   <= '0;
        ustep_q[c] <= 3'd1;
      end
      dir_q   <= '0;
      step_q  <= '0;
      done_q  <= '0;
      error_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ustep_q <= ustep_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
      error_q <= error_d;
      resp_q  <= resp_d;
    end
  end
endmodule

// File: tb/tb_step_command_engine.sv
// tb_step_command_engine: table of single-word commands plus hand-written
// multi-cycle sequences for step timing, STOP, SET_DIV and reset mid-move.
module tb_step_command_engine;
  logic        clk = 1'b0, resetn = 1'b0, wr = 1'b0;
  logic [31:0] wd = '0, resp;
  logic [1:0]  step, dir, busy, done;
  logic [5:0]  us;
  int checks = 0, failures = 0;

  step_command_engine dut (
    .CLK(clk), .resetn(resetn), .word_received(wr), .word_data_received(wd),
    .word_send_data(resp), .step(step), .dir(dir), .microsteps(us),
    .busy(busy), .move_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] resp;
    logic [5:0]  us;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic [31:0] w);
    @(negedge clk);
    wr = 1'b1;
    wd = w;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_step"}, 32'(step), 0);
    chk({name, "_dir"},  32'(dir),  0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_us"},   32'(us),   32'h09);
    chk({name, "_resp"}, resp,      0);
  endtask

  initial begin
    int n, first;
    logic act;
    tbl[0]  = '{32'h4100_0004, 32'h4100_0004, 6'h21};
    tbl[1]  = '{32'h6900_0000, 32'h6900_0000, 6'h21};
    tbl[2]  = '{32'h7000_0000, 32'h7080_0000, 6'h21};
    tbl[3]  = '{32'h7000_0000, 32'h7000_0000, 6'h21};
    tbl[4]  = '{32'hF300_0000, 32'hF300_0000, 6'h21};
    tbl[5]  = '{32'h1000_0000, 32'h1000_0000, 6'h21};
    tbl[6]  = '{32'h7000_0000, 32'h7000_0000, 6'h21};
    tbl[7]  = '{32'h4000_0007, 32'h4000_0007, 6'h27};
    tbl[8]  = '{32'h6100_0000, 32'h6100_0000, 6'h27};
    tbl[9]  = '{32'h5200_0000, 32'h5200_0000, 6'h27};
    tbl[10] = '{32'h7000_0000, 32'h7080_0000, 6'h27};
    tbl[11] = '{32'h4000_0001, 32'h4000_0001, 6'h21};

    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cmd(tbl[i].word);
      chk($sformatf("tbl%0d_resp", i), resp, tbl[i].resp);
      chk($sformatf("tbl%0d_us", i), 32'(us), 32'(tbl[i].us));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 0);
    end

    // Four steps at divisor 3: pulses every 4 CLKs, done with busy falling.
    cmd(32'h3000_0003);
    cmd(32'h1000_0004);
    chk("a_busy0", 32'(busy), 32'h1);
    chk("a_dir0", 32'(dir), 0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("a_step_k%0d", k), 32'(step), 32'((k % 4 == 0 && k <= 16) ? 2'b01 : 2'b00));
      chk($sformatf("a_done_k%0d", k), 32'(done), 32'((k == 16) ? 2'b01 : 2'b00));
      chk($sformatf("a_busy_k%0d", k), 32'(busy), 32'((k < 16) ? 2'b01 : 2'b00));
    end

    // Busy rejection, error reporting and STOP after three steps at divisor 9.
    cmd(32'h3000_0009);
    cmd(32'h1000_0064);
    cmd(32'h2000_0002);
    chk("b_dir_kept", 32'(dir), 0);
    chk("b_busy_kept", 32'(busy), 32'h1);
    cmd(32'h7000_0000);
    chk("b_glb_err", resp, 32'h7080_0001);
    cmd(32'h7000_0000);
    chk("b_glb_clr", resp, 32'h7000_0001);
    n = 0;
    act = 1'b0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge clk);
      if (step[0]) n++;
      if (done[0]) act = 1'b1;
    end
    chk("b_pulses", 32'(n), 3);
    cmd(32'h5000_0000);
    chk("b_stop_step", 32'(step), 0);
    chk("b_stop_busy", 32'(busy), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step != 2'b00 || done != 2'b00) act = 1'b1;
    end
    chk("b_quiet", 32'(act), 0);
    cmd(32'h6000_0000);
    chk("b_rem_zero", resp, 32'h6000_0000);

    // SET_DIV below the running count fires on the next cycle, then 11-CLK spacing.
    cmd(32'h3000_03E8);
    cmd(32'h1000_0064);
    repeat (498) @(negedge clk);
    cmd(32'h3000_000A);
    chk("c_no_step_yet", 32'(step), 0);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      chk($sformatf("c_step_k%0d", k), 32'(step), 32'((k == 1 || k == 12 || k == 23) ? 2'b01 : 2'b00));
    end
    cmd(32'h5000_0000);
    chk("c_stop_busy", 32'(busy), 0);

    // Divisor 0 is clamped to 1: step every 2 CLKs.
    cmd(32'h3000_0000);
    cmd(32'h1000_0002);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("z_step_k%0d", k), 32'(step), 32'((k == 2 || k == 4) ? 2'b01 : 2'b00));
      chk($sformatf("z_done_k%0d", k), 32'(done), 32'((k == 4) ? 2'b01 : 2'b00));
    end

    // Channel 1 reverse move at the default divisor; channel 0 stays idle.
    cmd(32'h2100_0002);
    chk("d_dir", 32'(dir), 32'h2);
    chk("d_busy", 32'(busy), 32'h2);
    first = 0;
    act = 1'b0;
    for (int k = 1; k <= 50010 && first == 0; k++) begin
      @(negedge clk);
      if (step[0] || done[0] || busy[0]) act = 1'b1;
      if (step[1]) first = k;
    end
    chk("d_first_pulse", 32'(first), 50001);
    chk("d_ch0_idle", 32'(act), 0);
    chk("d_still_busy", 32'(busy), 32'h2);

    // Asynchronous reset in the middle of the move.
    #2 resetn = 1'b0;
    #1 chk_reset_state("mid_rst");
    repeat (3) @(negedge clk);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
